// File: rtl/mips_pipe_pkg.sv
// rtl/mips_pipe_pkg.sv - shared stage control record and bubble constant for the E/M/W tracker
package mips_pipe_pkg;

    localparam int REG_W = 5;
    localparam int MTR_W = 2;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] write_reg;
        logic             reg_write;
        logic [MTR_W-1:0] mem_to_reg;
    } stage_ctrl_t;

    localparam stage_ctrl_t BUBBLE = '0;

endpackage

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - one pipeline control register, priority reset > hold > bubble > load
module pipe_stage_reg
    import mips_pipe_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        hold,
    input  logic        bubble,
    input  stage_ctrl_t d,
    output stage_ctrl_t q
);

    stage_ctrl_t stage_d;
    stage_ctrl_t stage_q;

    always_comb begin
        stage_d = d;
        if (reset) begin
            stage_d = BUBBLE;
        end else if (hold) begin
            stage_d = stage_q;
        end else if (bubble) begin
            stage_d = BUBBLE;
        end
    end

    always_ff @(posedge clk) begin
        stage_q <= stage_d;
    end

    assign q = stage_q;

endmodule

// File: rtl/hazard_pipe_tracker.sv
// rtl/hazard_pipe_tracker.sv - D->E->M->W control pipeline feeding the hazard unit; HAZARD_PERF_CNT_EN adds bubble/retire counters
module hazard_pipe_tracker
    import mips_pipe_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] rsD,
    input  logic [REG_W-1:0] rtD,
    input  logic [REG_W-1:0] WriteRegD,
    input  logic             RegWriteD,
    input  logic [MTR_W-1:0] MemtoRegD,
    input  logic             ValidD,
    input  logic             StallD,
    input  logic             FlushE,
    input  logic             StallE,
    output logic [REG_W-1:0] rsE,
    output logic [REG_W-1:0] rtE,
    output logic [REG_W-1:0] WriteRegE,
    output logic             RegWriteE,
    output logic [MTR_W-1:0] MemtoRegE,
    output logic [REG_W-1:0] WriteRegM,
    output logic             RegWriteM,
    output logic [MTR_W-1:0] MemtoRegM,
    output logic [REG_W-1:0] WriteRegW,
    output logic             RegWriteW,
    output logic             RetireW,
    output logic [CNT_W-1:0] BubbleCnt,
    output logic [CNT_W-1:0] RetireCnt
);

    stage_ctrl_t d_fields;
    stage_ctrl_t w_in;
    stage_ctrl_t e_q;
    stage_ctrl_t m_q;
    stage_ctrl_t w_q;
    logic        unused_sig;

    // An invalid D slot keeps its operand fields but can never match as a writer.
    always_comb begin
        d_fields            = BUBBLE;
        d_fields.valid      = ValidD;
        d_fields.rs         = rsD;
        d_fields.rt         = rtD;
        d_fields.mem_to_reg = MemtoRegD;
        d_fields.write_reg  = ValidD ? WriteRegD : '0;
        d_fields.reg_write  = ValidD & RegWriteD;
    end

    always_comb begin
        w_in           = BUBBLE;
        w_in.valid     = m_q.valid;
        w_in.write_reg = m_q.write_reg;
        w_in.reg_write = m_q.reg_write;
    end

    pipe_stage_reg u_stage_e (
        .clk    (clk),
        .reset  (reset),
        .hold   (StallE),
        .bubble (FlushE),
        .d      (d_fields),
        .q      (e_q)
    );

    pipe_stage_reg u_stage_m (
        .clk    (clk),
        .reset  (reset),
        .hold   (1'b0),
        .bubble (StallE),
        .d      (e_q),
        .q      (m_q)
    );

    pipe_stage_reg u_stage_w (
        .clk    (clk),
        .reset  (reset),
        .hold   (1'b0),
        .bubble (1'b0),
        .d      (w_in),
        .q      (w_q)
    );

    assign rsE       = e_q.rs;
    assign rtE       = e_q.rt;
    assign WriteRegE = e_q.write_reg;
    assign RegWriteE = e_q.reg_write;
    assign MemtoRegE = e_q.mem_to_reg;
    assign WriteRegM = m_q.write_reg;
    assign RegWriteM = m_q.reg_write;
    assign MemtoRegM = m_q.mem_to_reg;
    assign WriteRegW = w_q.write_reg;
    assign RegWriteW = w_q.reg_write;
    assign RetireW   = w_q.valid;

    // D-stage hold is handled upstream; M/W operand fields are not consumed.
    assign unused_sig = ^{StallD, m_q.rs, m_q.rt, w_q.rs, w_q.rt, w_q.mem_to_reg};

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] bubble_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q;
    logic [CNT_W-1:0] retire_cnt_d;
    logic [CNT_W-1:0] retire_cnt_q;
    logic             e_bubble_evt;
    logic             m_bubble_evt;

    always_comb begin
        e_bubble_evt = !reset && !StallE && (FlushE || !ValidD);
        m_bubble_evt = !reset && StallE;
        bubble_cnt_d = bubble_cnt_q + CNT_W'(e_bubble_evt) + CNT_W'(m_bubble_evt);
        retire_cnt_d = retire_cnt_q + CNT_W'(RetireW);
        if (reset) begin
            bubble_cnt_d = '0;
            retire_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        bubble_cnt_q <= bubble_cnt_d;
        retire_cnt_q <= retire_cnt_d;
    end

    assign BubbleCnt = bubble_cnt_q;
    assign RetireCnt = retire_cnt_q;
`else
    assign BubbleCnt = '0;
    assign RetireCnt = '0;
`endif

endmodule

// File: tb/tb_hazard_pipe_tracker.sv
// tb/tb_hazard_pipe_tracker.sv - scoreboard bench for hazard_pipe_tracker
module tb_hazard_pipe_tracker;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  rsD = '0, rtD = '0, WriteRegD = '0;
    logic        RegWriteD = 1'b0;
    logic [1:0]  MemtoRegD = '0;
    logic        ValidD = 1'b0, StallD = 1'b0, FlushE = 1'b0, StallE = 1'b0;
    logic [4:0]  rsE, rtE, WriteRegE, WriteRegM, WriteRegW;
    logic        RegWriteE, RegWriteM, RegWriteW, RetireW;
    logic [1:0]  MemtoRegE, MemtoRegM;
    logic [31:0] BubbleCnt, RetireCnt;

    hazard_pipe_tracker #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .rsD(rsD), .rtD(rtD), .WriteRegD(WriteRegD),
        .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .ValidD(ValidD),
        .StallD(StallD), .FlushE(FlushE), .StallE(StallE),
        .rsE(rsE), .rtE(rtE), .WriteRegE(WriteRegE), .RegWriteE(RegWriteE),
        .MemtoRegE(MemtoRegE), .WriteRegM(WriteRegM), .RegWriteM(RegWriteM),
        .MemtoRegM(MemtoRegM), .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
        .RetireW(RetireW), .BubbleCnt(BubbleCnt), .RetireCnt(RetireCnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rs_e, rt_e, wr_e, wr_m, wr_w;
        logic        rw_e, rw_m, rw_w, ret_w;
        logic [1:0]  mtr_e, mtr_m;
        logic [31:0] bcnt, rcnt;
    } exp_t;

    exp_t exp_q[$];

    // Reference pipeline state
    logic        ev, mv, wv;
    logic [4:0]  ers, ert, ewr, mwr, wwr;
    logic        erw, mrw, wrw;
    logic [1:0]  emtr, mmtr;
    logic [31:0] bc, rc;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_step();
        if (reset) begin
            {ev, mv, wv, erw, mrw, wrw} = '0;
            {ers, ert, ewr, mwr, wwr, emtr, mmtr} = '0;
            bc = 0;
            rc = 0;
        end else begin
            rc = rc + 32'(wv);
            bc = bc + 32'(StallE) + 32'(!StallE && (FlushE || !ValidD));
            wv = mv; wwr = mwr; wrw = mrw;
            if (StallE) begin
                mv = 0; mwr = 0; mrw = 0; mmtr = 0;
            end else begin
                mv = ev; mwr = ewr; mrw = erw; mmtr = emtr;
                if (FlushE) begin
                    ev = 0; ers = 0; ert = 0; ewr = 0; erw = 0; emtr = 0;
                end else begin
                    ev = ValidD; ers = rsD; ert = rtD; emtr = MemtoRegD;
                    ewr = ValidD ? WriteRegD : 5'd0;
                    erw = ValidD & RegWriteD;
                end
            end
        end
    endtask

    task automatic cycle(input logic rst, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] wr, input logic rw, input logic [1:0] mtr,
                         input logic fl, input logic st);
        exp_t e;
        exp_t o;
        reset = rst; ValidD = v; rsD = rs; rtD = rt; WriteRegD = wr; RegWriteD = rw;
        MemtoRegD = mtr; FlushE = fl; StallE = st; StallD = fl;
        model_step();
        e.rs_e = ers; e.rt_e = ert; e.wr_e = ewr; e.rw_e = erw; e.mtr_e = emtr;
        e.wr_m = mwr; e.rw_m = mrw; e.mtr_m = mmtr;
        e.wr_w = wwr; e.rw_w = wrw; e.ret_w = wv;
`ifdef HAZARD_PERF_CNT_EN
        e.bcnt = bc; e.rcnt = rc;
`else
        e.bcnt = 0; e.rcnt = 0;
`endif
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        o = exp_q.pop_front();
        check("rsE", 32'(rsE), 32'(o.rs_e));
        check("rtE", 32'(rtE), 32'(o.rt_e));
        check("WriteRegE", 32'(WriteRegE), 32'(o.wr_e));
        check("RegWriteE", 32'(RegWriteE), 32'(o.rw_e));
        check("MemtoRegE", 32'(MemtoRegE), 32'(o.mtr_e));
        check("WriteRegM", 32'(WriteRegM), 32'(o.wr_m));
        check("RegWriteM", 32'(RegWriteM), 32'(o.rw_m));
        check("MemtoRegM", 32'(MemtoRegM), 32'(o.mtr_m));
        check("WriteRegW", 32'(WriteRegW), 32'(o.wr_w));
        check("RegWriteW", 32'(RegWriteW), 32'(o.rw_w));
        check("RetireW", 32'(RetireW), 32'(o.ret_w));
        check("BubbleCnt", BubbleCnt, o.bcnt);
        check("RetireCnt", RetireCnt, o.rcnt);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #1;
        // Reset for two cycles with a live instruction presented
        cycle(1, 1, 1, 2, 5, 1, 0, 0, 0);
        cycle(1, 1, 1, 2, 5, 1, 0, 0, 0);
        cycle(0, 1, 1, 2, 5, 1, 1, 0, 0);
        idle(4);
        // Load-use: flush one cycle, D repeats the instruction
        cycle(0, 1, 3, 8, 4, 1, 1, 1, 0);
        cycle(0, 1, 3, 8, 4, 1, 1, 0, 0);
        idle(4);
        // Multi-cycle execute holds WriteReg 9 for three extra cycles
        cycle(0, 1, 6, 7, 9, 1, 0, 0, 0);
        cycle(0, 1, 1, 1, 10, 1, 0, 0, 1);
        cycle(0, 1, 1, 1, 10, 1, 0, 0, 1);
        cycle(0, 1, 1, 1, 10, 1, 0, 0, 1);
        idle(5);
        // Stall and flush together: E must hold
        cycle(0, 1, 2, 3, 11, 1, 2, 0, 0);
        cycle(0, 1, 4, 4, 12, 1, 0, 1, 1);
        cycle(0, 1, 4, 4, 12, 1, 0, 0, 0);
        idle(4);
        // Reset during a stall drops the held instruction
        cycle(0, 1, 5, 5, 13, 1, 3, 0, 0);
        cycle(0, 1, 5, 5, 14, 1, 0, 0, 1);
        cycle(1, 1, 5, 5, 14, 1, 0, 0, 1);
        idle(4);
        // Ten back-to-back instructions
        for (int i = 0; i < 10; i++) cycle(0, 1, 5'(i), 5'(i + 1), 5'(i + 16), 1, 2'(i), 0, 0);
        idle(5);
        // Random traffic
        for (int i = 0; i < 60; i++) begin
            cycle(($urandom_range(0, 29) == 0), 1'($urandom), 5'($urandom), 5'($urandom),
                  5'($urandom), 1'($urandom), 2'($urandom),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end
        idle(4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_pipe_tracker.md
Name: hazard_pipe_tracker

Overview:
- Other end of the hazard unit's interface: consumes StallD/FlushE and generates every E/M/W-stage field the hazard unit reads (rsE, rtE, WriteRegE/M/W, RegWriteE/M/W, MemtoRegE/M).
- Holds the D→E, E→M and M→W control/register-address pipeline registers with bubble insertion.
- Accepts a hold request from multi-cycle execute units.
- Provides a per-instruction retire pulse.

Parameters:
- REG_W, 5, register-address width
- MTR_W, 2, MemtoReg field width
- CNT_W, 32, performance counter width (optional feature only)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- rsD  in  REG_W  decode-stage rs
- rtD  in  REG_W  decode-stage rt
- WriteRegD  in  REG_W  decode-stage destination register
- RegWriteD  in  1  decode-stage register-write enable
- MemtoRegD  in  MTR_W  decode-stage load select
- ValidD  in  1  decode stage holds a real instruction
- StallD  in  1  from hazard unit; informational, D-stage hold is external
- FlushE  in  1  from hazard unit; inject bubble into E
- StallE  in  1  multi-cycle execute unit busy; hold E, bubble into M
- rsE, rtE  out  REG_W  E-stage sources
- WriteRegE  out  REG_W  E-stage destination
- RegWriteE  out  1  E-stage register-write enable
- MemtoRegE  out  MTR_W  E-stage load select
- WriteRegM  out  REG_W  M-stage destination
- RegWriteM  out  1  M-stage register-write enable
- MemtoRegM  out  MTR_W  M-stage load select
- WriteRegW  out  REG_W  W-stage destination
- RegWriteW  out  1  W-stage register-write enable
- RetireW  out  1  one-cycle pulse: valid instruction in W this cycle
- BubbleCnt  out  CNT_W  bubbles injected (PERF_CNT_EN only)
- RetireCnt  out  CNT_W  instructions retired (PERF_CNT_EN only)

Behaviour:
- Bubble definition: all fields zero, including valid. WriteReg=0 and RegWrite=0 together guarantee no forwarding or stall match.
- Reset: every E/M/W register becomes a bubble. All outputs are 0 the cycle after reset is sampled high. Reset overrides all other inputs. Reset asserted mid-stall drops the held instruction.
- E-stage update, priority order:
  - reset → bubble
  - StallE=1 → hold current E contents
  - FlushE=1 → bubble
  - else → load D fields, with validE ← ValidD
- StallE has priority over FlushE because a held E instruction must never be dropped.
- StallD with FlushE=0 and StallE=0 loads D as usual; upstream holds D, so a repeated instruction cannot occur because the hazard unit always pairs StallD with FlushE.
- M-stage update:
  - reset → bubble
  - StallE=1 → bubble, so the held E instruction is not duplicated
  - else → load E
- W-stage update: reset → bubble; else load M. W never stalls.
- Latency: a D instruction with no stalls reaches E in 1 cycle, M in 2, W in 3. Each StallE cycle adds 1 cycle of E residency.
- RetireW is registered validW.
- MemtoRegW is not exported; the W stage carries only validW, WriteRegW and RegWriteW.
- ValidD=0 loads a bubble-equivalent E entry. Its fields are still loaded, but RegWriteE is forced to 0 and WriteRegE to 0.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - BubbleCnt increments once per cycle in which E loads a bubble due to FlushE or ValidD=0. Reset-forced bubbles do not count.
  - BubbleCnt also increments once per cycle in which M loads a StallE bubble.
  - If both events occur in one cycle, BubbleCnt increments by 2.
  - RetireCnt increments on RetireW.
  - Both counters wrap modulo 2^CNT_W and reset to 0.
- Undefined: counter logic is absent and BubbleCnt/RetireCnt are tied to 0.

Decomposition:
- Shared package mips_pipe_pkg:
  - REG_W and MTR_W constants
  - stage_ctrl_t packed struct: valid, rs, rt, WriteReg, RegWrite, MemtoReg
  - BUBBLE constant of type stage_ctrl_t
- One sub-module, pipe_stage_reg: one stage_ctrl_t register with reset, hold and bubble inputs and fixed priority reset > hold > bubble > load.
  - Instantiated for E, M and W; W ties hold to 0.

Test Plan:
- Reset held 2 cycles, then released with ValidD=1, WriteRegD=5, RegWriteD=1 → all outputs 0 during reset; WriteRegE=5 one cycle after release, WriteRegM=5 after 2 cycles, WriteRegW=5 with RetireW=1 after 3 cycles.
- Load-use: FlushE=1 for one cycle with D holding rtD=8 → E shows a bubble (RegWriteE=0, rtE=0) that cycle; the next cycle E=rt 8; W sees the gap one cycle later; BubbleCnt=1.
- StallE=1 for 3 cycles with E holding WriteReg=9 → WriteRegE stays 9 for 4 cycles; M gets 3 bubbles; W later shows 9 exactly once, with RetireCnt incrementing by exactly 1.
- StallE=1 and FlushE=1 in the same cycle → E holds its instruction unchanged; M gets a bubble.
- Reset pulsed while StallE=1 → E, M and W all bubble next cycle; the held instruction never retires.
- Back-to-back 10 valid instructions, no stalls → RetireW high for 10 consecutive cycles starting 3 cycles after the first; RetireCnt=10, BubbleCnt=0.
